// File: rtl/inst_fetch_pkg.sv
// Shared types and AXI4 constants for the instruction line-fetch master.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } fetch_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/fetch_line_buf.sv
// Line assembly buffer: LINE_WORDS x 32-bit registers, one indexed write port,
// whole line visible on a flat read-out bus.
module fetch_line_buf #(
    parameter int LINE_WORDS = 8,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [IDX_W-1:0]         idx,
    input  logic [31:0]              wdata,
    output logic [32*LINE_WORDS-1:0] line
);

    logic [31:0] words [LINE_WORDS];

    // NOTE: this array is reset on purpose because resp_data must read zero after reset;
    // storage with no observable reset value would normally be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                words[i] <= '0;
            end
        end else if (we) begin
            words[idx] <= wdata;
        end
    end

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_flat
        assign line[32*g +: 32] = words[g];
    end

endmodule

// File: rtl/inst_line_fetch.sv
// Instruction-side AXI4 read master: one aligned INCR burst per cache-line refill,
// beats assembled into a line buffer and returned with a sticky error flag.
module inst_line_fetch
    import inst_fetch_pkg::*;
#(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                     cpu_clk,
    input  logic                     cpu_reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [32*LINE_WORDS-1:0] resp_data,
    output logic                     resp_err,
    output logic [ADDR_W-1:0]        cpu_inst_araddr,
    output logic                     cpu_inst_arvalid,
    input  logic                     cpu_inst_arready,
    output logic [7:0]               cpu_inst_arlen,
    output logic [2:0]               cpu_inst_arsize,
    output logic [1:0]               cpu_inst_arburst,
    input  logic [31:0]              cpu_inst_rdata,
    input  logic                     cpu_inst_rvalid,
    output logic                     cpu_inst_rready,
    input  logic                     cpu_inst_rlast,
    input  logic [1:0]               cpu_inst_rresp
);

    localparam int                IDX_W    = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

    fetch_state_e      state, state_nxt;
    logic              init_done;
    logic              arvalid_q, resp_valid_q;
    logic              err_q, overflow_q;
    logic [IDX_W-1:0]  cnt;
    logic [ADDR_W-1:0] araddr_q;
    logic              req_fire, beat;

    // init_done holds req_ready low for the cycle in which reset values are shown.
    assign req_ready = (state == IDLE) && init_done;
    assign req_fire  = req_ready && req_valid;
    assign beat      = (state == DATA) && cpu_inst_rvalid;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create ordering-dependent behaviour.
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next state is defaulted before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire)                          state_nxt = ADDR;
            ADDR:    if (cpu_inst_arready)                  state_nxt = DATA;
            DATA:    if (cpu_inst_rvalid && cpu_inst_rlast) state_nxt = RESP;
            RESP:    if (resp_ready)                        state_nxt = IDLE;
            default:                                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            init_done    <= 1'b0;
            arvalid_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            araddr_q     <= '0;
            cnt          <= '0;
            err_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            init_done    <= 1'b1;
            arvalid_q    <= (state_nxt == ADDR);
            resp_valid_q <= (state_nxt == RESP);
            if (req_fire) begin
                araddr_q   <= req_addr & ~OFF_MASK;
                cnt        <= '0;
                err_q      <= 1'b0;
                overflow_q <= 1'b0;
            end
            if (beat) begin
                if (cnt != LAST_IDX) begin
                    cnt <= cnt + IDX_W'(1);
                end
                if (cpu_inst_rresp != AXI_RESP_OKAY) begin
                    err_q <= 1'b1;
                end
                // Short burst: rlast before the final word.
                if (cpu_inst_rlast && cnt != LAST_IDX) begin
                    err_q <= 1'b1;
                end
                // Long burst: the last slot is filled but the slave keeps going.
                if (!cpu_inst_rlast && cnt == LAST_IDX) begin
                    err_q      <= 1'b1;
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    fetch_line_buf #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buf (
        .clk   (cpu_clk),
        .rst   (cpu_reset),
        .we    (beat && !overflow_q),
        .idx   (cnt),
        .wdata (cpu_inst_rdata),
        .line  (resp_data)
    );

    assign resp_valid       = resp_valid_q;
    assign resp_err         = err_q;
    assign cpu_inst_araddr  = araddr_q;
    assign cpu_inst_arvalid = arvalid_q;
    assign cpu_inst_rready  = (state == DATA);
    assign cpu_inst_arlen   = 8'(LINE_WORDS - 1);
    assign cpu_inst_arsize  = AXI_SIZE_4B;
    assign cpu_inst_arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_inst_line_fetch.sv
// Directed bench for inst_line_fetch: acts as requester, AXI read slave and consumer.
module tb_inst_line_fetch;

    localparam int LW = 8;
    localparam int AW = 32;

    logic            cpu_clk = 1'b0;
    logic            cpu_reset;
    logic            req_valid, req_ready;
    logic [AW-1:0]   req_addr;
    logic            resp_valid, resp_ready, resp_err;
    logic [32*LW-1:0] resp_data;
    logic [AW-1:0]   araddr;
    logic            arvalid, arready;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [31:0]     rdata;
    logic            rvalid, rready, rlast;
    logic [1:0]      rresp;

    inst_line_fetch #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .cpu_clk          (cpu_clk),
        .cpu_reset        (cpu_reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_err         (resp_err),
        .cpu_inst_araddr  (araddr),
        .cpu_inst_arvalid (arvalid),
        .cpu_inst_arready (arready),
        .cpu_inst_arlen   (arlen),
        .cpu_inst_arsize  (arsize),
        .cpu_inst_arburst (arburst),
        .cpu_inst_rdata   (rdata),
        .cpu_inst_rvalid  (rvalid),
        .cpu_inst_rready  (rready),
        .cpu_inst_rlast   (rlast),
        .cpu_inst_rresp   (rresp)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0]     obs_araddr;
    int              obs_ar_moves;
    int              obs_early_resp;
    int              obs_not_ready;
    logic            obs_resp_u1;
    int              obs_resp_moved;
    logic [31:0]     obs_words [LW];
    logic            obs_err;
    logic            obs_after_valid;
    logic            obs_after_ready;
    logic [31:0]     prev_words [LW];

    task automatic req_phase(input logic [31:0] addr, input int ar_delay);
        int waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge cpu_clk);
            waited++;
        end
        check("req_ready_wait", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge cpu_clk);
        req_valid = 1'b0;
        req_addr  = '0;
        check("arvalid_t1", 64'(arvalid), 64'(1));
        check("rready_in_addr", 64'(rready), 64'(0));
        obs_araddr   = araddr;
        obs_ar_moves = 0;
        for (int i = 0; i < ar_delay; i++) begin
            @(negedge cpu_clk);
            if (araddr !== obs_araddr || arvalid !== 1'b1) obs_ar_moves++;
        end
        arready = 1'b1;
        @(negedge cpu_clk);
        arready = 1'b0;
        check("arvalid_drop", 64'(arvalid), 64'(0));
    endtask

    // Presents up to nbeats beats (stops early after stop_after beats when >= 0).
    task automatic data_phase(input logic [31:0] base, input int nbeats, input int err_idx,
                              input int max_gap, input int stop_after);
        obs_early_resp = 0;
        obs_not_ready  = 0;
        for (int b = 0; b < nbeats; b++) begin
            if (stop_after >= 0 && b >= stop_after) break;
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge cpu_clk);
            if (rready !== 1'b1) obs_not_ready++;
            rvalid = 1'b1;
            rdata  = base + 32'(b);
            rlast  = (b == nbeats - 1);
            rresp  = (b == err_idx) ? 2'b10 : 2'b00;
            @(negedge cpu_clk);
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            rdata  = '0;
            if (b != nbeats - 1 && resp_valid === 1'b1) obs_early_resp++;
        end
        obs_resp_u1 = resp_valid;
    endtask

    task automatic resp_phase(input int resp_delay);
        logic [32*LW-1:0] snap;
        snap           = resp_data;
        obs_resp_moved = 0;
        for (int i = 0; i < resp_delay; i++) begin
            @(negedge cpu_clk);
            if (resp_valid !== 1'b1 || resp_data !== snap) obs_resp_moved++;
        end
        resp_ready = 1'b1;
        for (int i = 0; i < LW; i++) obs_words[i] = resp_data[32*i +: 32];
        obs_err = resp_err;
        @(negedge cpu_clk);
        resp_ready      = 1'b0;
        obs_after_valid = resp_valid;
        obs_after_ready = req_ready;
    endtask

    task automatic check_words(input string tag, input logic [31:0] base, input int n_new);
        for (int i = 0; i < LW; i++) begin
            if (i < n_new) check(tag, 64'(obs_words[i]), 64'(base + 32'(i)));
            else           check(tag, 64'(obs_words[i]), 64'(prev_words[i]));
        end
        for (int i = 0; i < LW; i++) prev_words[i] = obs_words[i];
    endtask

    initial begin
        cpu_reset  = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rdata      = '0;
        rlast      = 1'b0;
        rresp      = 2'b00;
        for (int i = 0; i < LW; i++) prev_words[i] = '0;

        // Reset state
        repeat (2) @(negedge cpu_clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_arvalid", 64'(arvalid), 64'(0));
        check("rst_rready", 64'(rready), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_resp_err", 64'(resp_err), 64'(0));
        check("rst_araddr", 64'(araddr), 64'(0));
        check("rst_resp_data", 64'(|resp_data), 64'(0));
        cpu_reset = 1'b0;
        @(negedge cpu_clk);
        check("post_rst_req_ready", 64'(req_ready), 64'(1));

        // Best-case line fill
        req_phase(32'h0000_1234, 0);
        check("fill_araddr", 64'(obs_araddr), 64'h1220);
        check("fill_arlen", 64'(arlen), 64'd7);
        check("fill_arsize", 64'(arsize), 64'd2);
        check("fill_arburst", 64'(arburst), 64'd1);
        data_phase(32'hA0, 8, -1, 0, -1);
        check("fill_rready", 64'(obs_not_ready), 64'(0));
        check("fill_resp_u1", 64'(obs_resp_u1), 64'(1));
        resp_phase(0);
        check_words("fill_word", 32'hA0, 8);
        check("fill_err", 64'(obs_err), 64'(0));
        check("fill_resp_drop", 64'(obs_after_valid), 64'(0));
        check("fill_idle_again", 64'(obs_after_ready), 64'(1));

        // Backpressure on AR, R and response
        req_phase(32'h0000_5678, 5);
        check("bp_araddr", 64'(obs_araddr), 64'h5660);
        check("bp_araddr_stable", 64'(obs_ar_moves), 64'(0));
        data_phase(32'hB0, 8, -1, 3, -1);
        check("bp_rready", 64'(obs_not_ready), 64'(0));
        check("bp_resp_u1", 64'(obs_resp_u1), 64'(1));
        resp_phase(4);
        check("bp_resp_held", 64'(obs_resp_moved), 64'(0));
        check_words("bp_word", 32'hB0, 8);
        check("bp_err", 64'(obs_err), 64'(0));

        // Slave error on beat 3
        req_phase(32'h0000_2000, 0);
        check("slverr_araddr", 64'(obs_araddr), 64'h2000);
        data_phase(32'hC0, 8, 3, 0, -1);
        check("slverr_rready", 64'(obs_not_ready), 64'(0));
        check("slverr_early", 64'(obs_early_resp), 64'(0));
        check("slverr_resp_u1", 64'(obs_resp_u1), 64'(1));
        resp_phase(0);
        check_words("slverr_word", 32'hC0, 8);
        check("slverr_err", 64'(obs_err), 64'(1));

        // Short burst: rlast on beat 5, words 5..7 keep the previous line
        req_phase(32'h0000_3004, 0);
        check("short_araddr", 64'(obs_araddr), 64'h3000);
        data_phase(32'hD0, 5, -1, 0, -1);
        check("short_resp_u1", 64'(obs_resp_u1), 64'(1));
        resp_phase(0);
        check_words("short_word", 32'hD0, 5);
        check("short_err", 64'(obs_err), 64'(1));

        // Long burst: 10 beats, last two discarded
        req_phase(32'h0000_7FFC, 0);
        check("long_araddr", 64'(obs_araddr), 64'h7FE0);
        data_phase(32'hE0, 10, -1, 0, -1);
        check("long_rready", 64'(obs_not_ready), 64'(0));
        check("long_early", 64'(obs_early_resp), 64'(0));
        check("long_resp_u1", 64'(obs_resp_u1), 64'(1));
        resp_phase(0);
        check_words("long_word", 32'hE0, 8);
        check("long_err", 64'(obs_err), 64'(1));

        // Reset after beat 3, then a clean request
        req_phase(32'h0000_6008, 0);
        data_phase(32'hF0, 8, -1, 0, 3);
        cpu_reset = 1'b1;
        @(negedge cpu_clk);
        check("mid_rst_req_ready", 64'(req_ready), 64'(0));
        check("mid_rst_arvalid", 64'(arvalid), 64'(0));
        check("mid_rst_rready", 64'(rready), 64'(0));
        check("mid_rst_resp_valid", 64'(resp_valid), 64'(0));
        check("mid_rst_resp_err", 64'(resp_err), 64'(0));
        check("mid_rst_araddr", 64'(araddr), 64'(0));
        check("mid_rst_resp_data", 64'(|resp_data), 64'(0));
        cpu_reset = 1'b0;
        for (int i = 0; i < LW; i++) prev_words[i] = '0;
        @(negedge cpu_clk);
        check("mid_rst_ready_back", 64'(req_ready), 64'(1));
        req_phase(32'h0000_4444, 0);
        check("after_rst_araddr", 64'(obs_araddr), 64'h4440);
        data_phase(32'h10, 8, -1, 0, -1);
        check("after_rst_resp_u1", 64'(obs_resp_u1), 64'(1));
        resp_phase(1);
        check_words("after_rst_word", 32'h10, 8);
        check("after_rst_err", 64'(obs_err), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_line_fetch.md
# inst_line_fetch

Instruction-side AXI4 read master that sits directly upstream of the crossbar's instruction input port (`io_in_1`, AR/R channels only). It accepts a cache-line refill request from the CPU core's instruction cache and issues one aligned AXI4 INCR burst read. It assembles the returned beats into a line buffer and hands the full line back with an error flag. It is read-only: the crossbar's write channels for this port stay tied off.

## Interface
Parameters:
- `LINE_WORDS`, 8: 32-bit words per line; power of two, 2..16.
- `ADDR_W`, 32: address width.

Ports:
- `cpu_clk`  in  1  sole clock.
- `cpu_reset`  in  1  reset; one clock; reset is synchronous and active-high.
- `req_valid`  in  1  refill request.
- `req_ready`  out  1  high only in IDLE.
- `req_addr`  in  ADDR_W  any byte address inside the wanted line.
- `resp_valid`  out  1  line ready.
- `resp_ready`  in  1  consumer accepts line.
- `resp_data`  out  32*LINE_WORDS  word i in bits [32i+31:32i].
- `resp_err`  out  1  a bus or protocol error occurred during the burst.
- `cpu_inst_araddr`  out  ADDR_W  line-aligned burst address.
- `cpu_inst_arvalid`  out  1
- `cpu_inst_arready`  in  1
- `cpu_inst_arlen`  out  8  constant LINE_WORDS-1.
- `cpu_inst_arsize`  out  3  constant 3'b010.
- `cpu_inst_arburst`  out  2  constant 2'b01 (INCR).
- `cpu_inst_rdata`  in  32
- `cpu_inst_rvalid`  in  1
- `cpu_inst_rready`  out  1
- `cpu_inst_rlast`  in  1
- `cpu_inst_rresp`  in  2

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_addr` with the low log2(LINE_WORDS*4) bits cleared.
  - Clear the beat counter and the error flag, then go to ADDR.
- ADDR:
  - `arvalid`=1 with a stable `araddr`.
  - On `arready`, go to DATA.
- DATA:
  - `rready`=1.
  - Each `rvalid` beat writes `rdata` into word[cnt]; cnt increments and saturates at LINE_WORDS-1.
  - `rresp`≠2'b00 on any beat sets the sticky err flag.
  - A beat with `rlast` ends the burst and moves the FSM to RESP.
- Protocol checks:
  - `rlast` with cnt<LINE_WORDS-1 sets err. The words not received keep their previous contents.
  - A beat at cnt=LINE_WORDS-1 without `rlast` sets err. Further beats are accepted and discarded until `rlast` arrives.
- RESP:
  - `resp_valid`=1; `resp_data` and `resp_err` are stable.
  - On `resp_ready`, go to IDLE.
- Reset values: `req_ready`=0 during the reset cycle and 1 afterwards. All other outputs are 0: `arvalid`, `rready`, `resp_valid`, `resp_err`, `araddr`, `resp_data`.
- Reset mid-burst returns the FSM to IDLE at once. The crossbar shares `cpu_reset`, so the AXI handshake being dropped is acceptable.
- Only one burst is in flight at a time; there is no ID usage. The crossbar assigns the ID.

## Timing
- `arvalid`, `resp_valid` and `resp_data` are registered outputs.
- `req_ready` and `rready` decode from the state register only. There is no combinational path from any input to any output.
- Latencies:
  - Request handshake at cycle t gives `arvalid`=1 at t+1.
  - The `rlast` beat at cycle u gives `resp_valid`=1 at u+1.
  - IDLE is re-entered the cycle after the `resp_ready` handshake. The next request can therefore be accepted one cycle after the response handshake.
- Best case with `arready`=1 and back-to-back `rvalid`: request at cycle 0, AR handshake at 1, beats at 2..LINE_WORDS+1, `resp_valid` at LINE_WORDS+2.
- `req_valid` in states other than IDLE is ignored; the requester must hold it.
- The AXI rules are followed: `arvalid` is never dropped before `arready`, and `araddr` does not change while `arvalid` is high.

## Structure
- Shared package `inst_fetch_pkg` holds:
  - the state enum;
  - the AXI constants `AXI_BURST_INCR`=2'b01, `AXI_SIZE_4B`=3'b010 and `AXI_RESP_OKAY`=2'b00.
- One sub-module, `fetch_line_buf`: a LINE_WORDS×32 register array with a write-enable and index input and a flat read-out bus. The FSM and the counter live in the top module.

## Test plan
- Line fill with `LINE_WORDS`=8:
  - Stimulus: request `req_addr`=0x0000_1234; memory returns 0xA0..0xA7, `rresp`=0.
  - Required: `araddr`=0x0000_1220, `arlen`=7, `arsize`=2, `arburst`=1; `resp_data` word i = 0xA0+i; `resp_err`=0.
- Backpressure:
  - Stimulus: `arready` delayed 5 cycles; `rvalid` gaps of 0–3 random cycles; `resp_ready` delayed 4 cycles.
  - Required: `araddr` stable while `arvalid` is high; data correct; `resp_valid` held until accepted.
- Slave error: beat 3 returns `rresp`=2'b10. Required: all 8 beats are consumed and `resp_err`=1.
- Short burst: `rlast` on beat 5. Required: `resp_valid` the next cycle, `resp_err`=1, and words 5–7 unchanged.
- Long burst: 10 beats with `rlast` on the 10th. Required: beats 9–10 are discarded, words 0–7 are correct, `resp_err`=1, and `resp_valid` comes after beat 10.
- Reset mid-burst:
  - Stimulus: assert `cpu_reset` after beat 3, then issue a new request.
  - Required: all outputs return to their reset values the next cycle; the new request completes cleanly with `resp_err`=0.
